// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial 32-bit ALU, one bit per clock LSB first, valid/ready in and out.
// Optional flag outputs (zero, cout, ovf) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_serial_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic        zero,
    output logic        cout,
    output logic        ovf
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                           OP_SLT = 4'd4, OP_NOR = 4'd5, OP_SRL = 4'd6, OP_SLL = 4'd7;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [30:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
`ifdef ALU_SEQ_FLAGS_EN
    logic        zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
`endif

    logic        sub_op, arith, ak, bk, sum, co, bit_v;
    logic [31:0] res_fin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
`endif
        sub_op = (op_q == OP_SUB) || (op_q == OP_SLT);
        arith  = sub_op || (op_q == OP_ADD);
        ak     = a_q[cnt_q];
        bk     = sub_op ? ~b_q[cnt_q] : b_q[cnt_q];
        sum    = ak ^ bk ^ carry_q;
        co     = (ak & bk) | (carry_q & (ak ^ bk));
        case (op_q)
            OP_AND:                 bit_v = ak & bk;
            OP_OR:                  bit_v = ak | bk;
            OP_NOR:                 bit_v = ~(ak | bk);
            OP_ADD, OP_SUB, OP_SLT: bit_v = sum;
            OP_SLL:                 bit_v = (cnt_q == 5'd0) ? 1'b0 : a_q[cnt_q - 5'd1];
            OP_SRL:                 bit_v = (cnt_q == 5'd31) ? 1'b0 : a_q[cnt_q + 5'd1];
            default:                bit_v = 1'b0;
        endcase
        // At bit 31, sum is the difference's sign and carry_q ^ co is the signed overflow.
        res_fin = (op_q == OP_SLT) ? {31'b0, sum ^ carry_q ^ co} : {bit_v, acc_q};
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = op;
                a_d     = a;
                b_d     = b;
                cnt_d   = '0;
                carry_d = (op == OP_SUB) || (op == OP_SLT);
                state_d = RUN;
            end
            RUN: begin
                // Bits shift in at the top so bit 0 lands at acc_q[0] after 31 steps.
                acc_d   = {bit_v, acc_q[30:1]};
                carry_d = arith & co;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = res_fin;
                    state_d  = DONE;
`ifdef ALU_SEQ_FLAGS_EN
                    zero_d   = (res_fin == 32'd0);
                    cout_d   = arith & co;
                    ovf_d    = arith & (carry_q ^ co);
`endif
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign zero = zero_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
`endif
endmodule
